// File: rtl/blake2s_block_buf.sv
// rtl/blake2s_block_buf.sv - BLAKE2s 64-byte message block buffer with offset counter
module blake2s_block_buf (
   input  logic        clk,
   input  logic        nreset,
   input  logic        data_v_i,
   input  logic [7:0]  data_i,
   input  logic [5:0]  data_idx_i,
   input  logic        block_first_i,
   input  logic        block_last_i,
   input  logic [63:0] ll_i,
   output logic        ready_o,
   output logic        blk_v_o,
   input  logic        blk_ready_i,
   input  logic        release_i,
   output logic        blk_first_o,
   output logic        blk_last_o,
   output logic [63:0] t_o,
   input  logic [3:0]  m_idx_i,
   output logic [31:0] m_o,
   output logic        err_o
);
   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_FULL = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;

   logic [1:0]  state_q;
   logic [5:0]  exp_q;
   logic [63:0] cnt_q;
   logic [31:0] words_q [16];

   logic        accept;
   logic        done;
   logic        new_msg;
   logic        bad_byte;
   logic [63:0] cnt_next;

   assign accept   = data_v_i && (state_q == ST_FILL);
   assign done     = accept && (data_idx_i == 6'd63);
   assign new_msg  = accept && (data_idx_i == 6'd0) && block_first_i;
   assign bad_byte = data_v_i && ((state_q != ST_FILL) || (data_idx_i != exp_q));
   assign cnt_next = block_first_i ? 64'd64 : cnt_q + 64'd64;

   assign ready_o = (state_q == ST_FILL);
   assign blk_v_o = (state_q == ST_FULL);
   assign m_o     = words_q[m_idx_i];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= ST_FILL;
         exp_q       <= 6'd0;
         cnt_q       <= 64'd0;
         t_o         <= 64'd0;
         blk_first_o <= 1'b0;
         blk_last_o  <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         case (state_q)
            ST_FILL: if (done) state_q <= ST_FULL;
            ST_FULL: if (blk_ready_i) state_q <= ST_BUSY;
            ST_BUSY: if (release_i) state_q <= ST_FILL;
            default: state_q <= ST_FILL;
         endcase

         // Resynchronise on the received index; 63+1 wraps back to 0.
         if (accept) exp_q <= data_idx_i + 6'd1;

         if (done) begin
            cnt_q       <= cnt_next;
            t_o         <= block_last_i ? ll_i : cnt_next;
            blk_first_o <= block_first_i;
            blk_last_o  <= block_last_i;
         end

         if (new_msg) err_o <= 1'b0;
         else if (bad_byte) err_o <= 1'b1;
      end
   end

   // Word storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (accept) words_q[data_idx_i[5:2]][{data_idx_i[1:0], 3'b000} +: 8] <= data_i;
   end
endmodule

// File: tb/tb_blake2s_block_buf.sv
// tb/tb_blake2s_block_buf.sv - self-checking bench for blake2s_block_buf
module tb_blake2s_block_buf;
   logic        clk = 1'b0;
   logic        nreset;
   logic        data_v_i;
   logic [7:0]  data_i;
   logic [5:0]  data_idx_i;
   logic        block_first_i;
   logic        block_last_i;
   logic [63:0] ll_i;
   logic        ready_o;
   logic        blk_v_o;
   logic        blk_ready_i;
   logic        release_i;
   logic        blk_first_o;
   logic        blk_last_o;
   logic [63:0] t_o;
   logic [3:0]  m_idx_i;
   logic [31:0] m_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   blake2s_block_buf dut (
      .clk(clk), .nreset(nreset), .data_v_i(data_v_i), .data_i(data_i),
      .data_idx_i(data_idx_i), .block_first_i(block_first_i), .block_last_i(block_last_i),
      .ll_i(ll_i), .ready_o(ready_o), .blk_v_o(blk_v_o), .blk_ready_i(blk_ready_i),
      .release_i(release_i), .blk_first_o(blk_first_o), .blk_last_o(blk_last_o),
      .t_o(t_o), .m_idx_i(m_idx_i), .m_o(m_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Reference model: message bytes, phase 0=collecting, 1=offered, 2=held by core
   logic [7:0]  mb [64];
   bit          mk [64];
   int          m_phase;
   int          m_exp;
   bit          m_err;
   logic [63:0] m_cnt;
   logic [63:0] m_t;
   bit          m_first;
   bit          m_last;

   typedef struct {
      bit          f;
      bit          l;
      logic [63:0] ll;
      logic [7:0]  base;
      logic [63:0] t;
      logic [31:0] w0;
      logic [31:0] w15;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_exp = 0; m_err = 0; m_cnt = 0; m_t = 0; m_first = 0; m_last = 0;
   endtask

   task automatic model_update(input bit v, input logic [7:0] d, input int idx,
                               input bit f, input bit l, input logic [63:0] ll,
                               input bit br, input bit rel);
      int ph;
      ph = m_phase;
      if (v) begin
         if (ph == 0) begin
            if (idx == 0 && f) m_err = 0;
            else if (idx != m_exp) m_err = 1;
            mb[idx] = d;
            mk[idx] = 1;
            m_exp = (idx + 1) % 64;
            if (idx == 63) begin
               m_cnt   = f ? 64'd64 : m_cnt + 64'd64;
               m_t     = l ? ll : m_cnt;
               m_first = f;
               m_last  = l;
               m_phase = 1;
            end
         end else begin
            m_err = 1;
         end
      end
      if (ph == 1 && br) m_phase = 2;
      if (ph == 2 && rel) m_phase = 0;
   endtask

   task automatic model_compare();
      int k;
      chk("ready", ready_o, (m_phase == 0));
      chk("blk_v", blk_v_o, (m_phase == 1));
      chk("err", err_o, m_err);
      chk("t", t_o, m_t);
      chk("blk_first", blk_first_o, m_first);
      chk("blk_last", blk_last_o, m_last);
      k = int'(m_idx_i);
      if (mk[4*k] && mk[4*k+1] && mk[4*k+2] && mk[4*k+3])
         chk("m_o", m_o, {mb[4*k+3], mb[4*k+2], mb[4*k+1], mb[4*k]});
   endtask

   task automatic step(input bit v, input logic [7:0] d, input logic [5:0] idx,
                       input bit f, input bit l, input logic [63:0] ll,
                       input bit br, input bit rel);
      data_v_i = v; data_i = d; data_idx_i = idx;
      block_first_i = f; block_last_i = l; ll_i = ll;
      blk_ready_i = br; release_i = rel;
      @(posedge clk);
      model_update(v, d, int'(idx), f, l, ll, br, rel);
      #1;
      data_v_i = 0; blk_ready_i = 0; release_i = 0;
      m_idx_i = 4'($urandom_range(0, 15));
      #1;
      model_compare();
   endtask

   task automatic send_block(input logic [7:0] base, input bit f, input bit l, input logic [63:0] ll);
      for (int i = 0; i < 64; i++) step(1, 8'(base + i), 6'(i), f, l, ll, 0, 0);
   endtask

   task automatic peek(input int k, input logic [31:0] exp, input string name);
      m_idx_i = 4'(k);
      #1;
      chk(name, m_o, exp);
   endtask

   initial begin
      vecs[0] = '{f:1, l:1, ll:64'd3,   base:8'h00, t:64'd3,   w0:32'h03020100, w15:32'h3F3E3D3C};
      vecs[1] = '{f:1, l:0, ll:64'd150, base:8'h00, t:64'd64,  w0:32'h03020100, w15:32'h3F3E3D3C};
      vecs[2] = '{f:0, l:0, ll:64'd150, base:8'h40, t:64'd128, w0:32'h43424140, w15:32'h7F7E7D7C};
      vecs[3] = '{f:0, l:1, ll:64'd150, base:8'h80, t:64'd150, w0:32'h83828180, w15:32'hBFBEBDBC};

      for (int i = 0; i < 64; i++) mk[i] = 0;
      model_reset();
      nreset = 0; data_v_i = 0; data_i = 0; data_idx_i = 0; block_first_i = 0;
      block_last_i = 0; ll_i = 0; blk_ready_i = 0; release_i = 0; m_idx_i = 0;
      #12;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_blk_v", blk_v_o, 1'b0);
      chk("rst_first", blk_first_o, 1'b0);
      chk("rst_last", blk_last_o, 1'b0);
      chk("rst_t", t_o, 64'd0);
      chk("rst_err", err_o, 1'b0);
      nreset = 1;

      // Single block then a three-block message
      for (int v = 0; v < 4; v++) begin
         send_block(vecs[v].base, vecs[v].f, vecs[v].l, vecs[v].ll);
         chk("tbl_blk_v", blk_v_o, 1'b1);
         chk("tbl_ready", ready_o, 1'b0);
         chk("tbl_t", t_o, vecs[v].t);
         chk("tbl_first", blk_first_o, vecs[v].f);
         chk("tbl_last", blk_last_o, vecs[v].l);
         peek(0, vecs[v].w0, "tbl_w0");
         peek(15, vecs[v].w15, "tbl_w15");
         step(0, 0, 0, 0, 0, 0, 1, 0);
         chk("tbl_accept_blk_v", blk_v_o, 1'b0);
         step(0, 0, 0, 0, 0, 0, 0, 1);
         chk("tbl_release_ready", ready_o, 1'b1);
      end

      // Backpressure, dropped byte in FULL, error cleared by a new first block
      for (int i = 0; i < 64; i++) step(1, 8'(i) ^ 8'h5A, 6'(i), 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("bp_blk_v", blk_v_o, 1'b1);
      step(1, 8'hAA, 6'd5, 0, 0, 0, 0, 0);
      chk("bp_err", err_o, 1'b1);
      peek(1, {8'h07 ^ 8'h5A, 8'h06 ^ 8'h5A, 8'h05 ^ 8'h5A, 8'h04 ^ 8'h5A}, "bp_word1");
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 8'h11, 6'd0, 1, 1, 64'd9, 0, 0);
      chk("bp_err_clear", err_o, 1'b0);
      for (int i = 1; i < 64; i++) step(1, 8'(i), 6'(i), 1, 1, 64'd9, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);

      // Index skip 0,1,3
      step(1, 8'hC0, 6'd0, 1, 0, 0, 0, 0);
      step(1, 8'hC1, 6'd1, 1, 0, 0, 0, 0);
      step(1, 8'hC3, 6'd3, 1, 0, 0, 0, 0);
      chk("skip_err", err_o, 1'b1);
      m_idx_i = 0;
      #1;
      chk("skip_byte3", m_o[31:24], 8'hC3);
      for (int i = 4; i < 64; i++) step(1, 8'(i), 6'(i), 1, 0, 0, 0, 0);
      chk("skip_blk_v", blk_v_o, 1'b1);

      // Simultaneous blk_ready and release in FULL
      step(0, 0, 0, 0, 0, 0, 1, 1);
      chk("sim_ready", ready_o, 1'b0);
      chk("sim_blk_v", blk_v_o, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("sim_hold", ready_o, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("sim_release", ready_o, 1'b1);

      // Randomised traffic against the model
      for (int c = 0; c < 1500; c++) begin
         bit v, f, l, br, rel;
         logic [5:0] idx;
         v   = ($urandom_range(0, 9) < 8);
         idx = ($urandom_range(0, 19) == 0) ? 6'($urandom) : 6'(m_exp);
         f   = 1'($urandom);
         l   = 1'($urandom);
         br  = 1'($urandom);
         rel = ($urandom_range(0, 2) == 0);
         step(v, 8'($urandom), idx, f, l, {$urandom, $urandom}, br, rel);
      end
      while (m_phase != 0) step(0, 0, 0, 0, 0, 0, 1, 1);

      // Asynchronous reset after 20 bytes (with a skip so err is set)
      for (int i = 0; i < 21; i++) if (i != 5) step(1, 8'(i + 3), 6'(i), 1, 0, 0, 0, 0);
      chk("ar_err_pre", err_o, 1'b1);
      #1 nreset = 0;
      #1;
      chk("ar_ready", ready_o, 1'b1);
      chk("ar_blk_v", blk_v_o, 1'b0);
      chk("ar_err", err_o, 1'b0);
      model_reset();
      #1 nreset = 1;
      send_block(8'h20, 0, 0, 64'd500);
      chk("ar_blk_v_done", blk_v_o, 1'b1);
      chk("ar_t", t_o, 64'd64);
      chk("ar_first", blk_first_o, 1'b0);
      peek(2, 32'h2B2A2928, "ar_word2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/blake2s_block_buf.md
# blake2s_block_buf

Message block buffer between `io_intf` and the BLAKE2s compression core. Collects the byte stream from `io_intf` (`data_v_o`, `data_o`, `data_idx_o`, `block_first_o`, `block_last_o`) into a 64-byte block of sixteen 32-bit little-endian words. Computes the BLAKE2 byte offset `t` and hands the complete block to the core through a valid/ready handshake. Holds the block stable until the core releases it.

## Interface
- No parameters; block size is fixed at 64 bytes / 16 words.
- `clk`  in  1  clock.
- `nreset`  in  1  reset; one clock, asynchronous assert, active-low.
- `data_v_i`  in  1  byte valid, from `io_intf.data_v_o`.
- `data_i`  in  8  byte value.
- `data_idx_i`  in  6  byte index within the block, 0..63.
- `block_first_i`  in  1  current block is the first of the message; level signal.
- `block_last_i`  in  1  current block is the last of the message; level signal.
- `ll_i`  in  64  total message length in bytes, from config.
- `ready_o`  out  1  buffer can accept bytes; drives `io_intf.ready_v_i`.
- `blk_v_o`  out  1  complete block offered to the core.
- `blk_ready_i`  in  1  core accepts the offered block.
- `release_i`  in  1  core finished with the words; buffer may refill.
- `blk_first_o`  out  1  offered/held block is the first block.
- `blk_last_o`  out  1  offered/held block is the last block.
- `t_o`  out  64  BLAKE2 offset counter for the held block.
- `m_idx_i`  in  4  word read address.
- `m_o`  out  32  word `m_idx_i`; combinational read.
- `err_o`  out  1  sticky protocol error.

## Operation
- Storage: 16 x 32-bit registers. Byte `data_idx_i = 4k+j` is written to word k, bits [8j+7:8j].
- FSM states:
  - FILL (reset state): `ready_o`=1. Each `data_v_i` writes its byte and increments the 6-bit expected-index counter `exp_q`.
    - If `data_idx_i` != `exp_q`, set `err_o`. The byte is still written at `data_idx_i`, and `exp_q` becomes `data_idx_i`+1.
    - A byte with index 63 completes the block. Capture `blk_first_o` <= `block_first_i` and `blk_last_o` <= `block_last_i`, update `t`, clear `exp_q`, go to FULL.
  - FULL: `blk_v_o`=1, `ready_o`=0. On `blk_ready_i`=1, go to BUSY.
  - BUSY: `blk_v_o`=0, `ready_o`=0. On `release_i`=1, go to FILL.
- A byte arriving in FULL or BUSY is dropped and sets `err_o`; storage is unchanged.
- `release_i` in FILL or FULL is ignored; it does not set `err_o`.
- Offset arithmetic uses a 64-bit byte count `cnt_q`, updated on block completion:
  - If `block_first_i`: `cnt_q` <= 64. Otherwise `cnt_q` <= `cnt_q`+64, wrapping mod 2^64.
  - `t_o` is registered at completion: `ll_i` if `block_last_i`, else the new `cnt_q`.
  - When a block is both first and last, `t_o` = `ll_i`.
- `err_o` is sticky. It clears only on reset or on a byte with index 0 and `block_first_i`=1 accepted in FILL (start of a new message).
- `m_o` is valid in FULL and BUSY. In FILL it shows partially written contents, which the core must not use.

## Timing
- Reset values: state FILL, `ready_o`=1, `blk_v_o`=0, `blk_first_o`=0, `blk_last_o`=0, `t_o`=0, `cnt_q`=0, `exp_q`=0, `err_o`=0. Word registers are not reset.
- Byte written at edge N is readable on `m_o` from cycle N+1.
- Index-63 byte sampled at edge N: `blk_v_o`=1 and `ready_o`=0 from cycle N+1. `t_o`, `blk_first_o` and `blk_last_o` are also valid from N+1.
- `blk_v_o`, `t_o`, `blk_*_o` and all words stay stable from FULL until `release_i`.
- Handshake: `blk_v_o`, once high, stays high until `blk_ready_i`; it falls the cycle after acceptance.
- `release_i` at edge M: `ready_o`=1 from cycle M+1. A byte presented in cycle M+1 is accepted.
- `blk_ready_i` and `release_i` high together in FULL: go to BUSY only; `release_i` is ignored.
- Reset asserted mid-block: abandon the partial block, clear `exp_q`, and return to FILL immediately, asynchronously.

## Test plan
- Single block message: 64 bytes with idx 0..63, `data_i`=idx, first=last=1, `ll_i`=3.
  - `blk_v_o` rises the cycle after idx 63; `t_o`=3, `blk_first_o`=1, `blk_last_o`=1.
  - `m_idx_i`=0 gives `m_o`=0x03020100; `m_idx_i`=15 gives 0x3F3E3D3C.
- Three-block message, `ll_i`=150: after each block, pulse `blk_ready_i` then `release_i`.
  - `t_o` = 64, then 128, then 150.
  - `blk_first_o` is 1 only on block 1; `blk_last_o` is 1 only on block 3.
  - `ready_o` returns to 1 the cycle after each `release_i`.
- Backpressure: hold `blk_ready_i`=0 for 10 cycles.
  - `blk_v_o` stays 1 and words stay unchanged.
  - A byte injected in FULL is dropped and `err_o`=1.
  - A new first block at idx 0 accepted in FILL clears `err_o`.
- Index skip: send idx 0,1,3.
  - `err_o`=1 after idx 3; byte 3 lands in word 0 bits [31:24].
  - Continuing with 4..63 completes the block normally.
- Simultaneous handshake: in FULL, assert `blk_ready_i` and `release_i` together.
  - State goes to BUSY and `ready_o` stays 0.
  - A later `release_i` alone returns to FILL.
- Async reset mid-block (after 20 bytes): `ready_o`=1, `blk_v_o`=0, `err_o`=0 before the next edge. A fresh 64-byte block then completes with `t_o` per its first/last flags.
